mano_bram_arbiter: RTL and testbench
====================================

MANO_BRAM_ARBITER -- requirements
Module: mano_bram_arbiter

Interface
REQ-001 Parameter MEM0_DATA_WIDTH, default 32, SHALL set the data width of all data ports.
REQ-002 Parameter MEM0_ADDR_WIDTH, default 12, SHALL set the width of all address ports.
REQ-003 s00_axi_aclk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 s00_axi_aresetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 cpu_valid / cpu_ready  in / out  1 / 1  SHALL be the Mano CPU (requester 0) request handshake.
REQ-006 cpu_we, cpu_addr, cpu_d  in  1 / ADDR / DATA  SHALL be the requester 0 write enable, word address and write data.
REQ-007 cpu_rvalid, cpu_q  out  1 / DATA  SHALL be the requester 0 read-response strobe and data.
REQ-008 host_valid, host_ready, host_we, host_addr, host_d, host_rvalid, host_q SHALL be the identical port set for the host (requester 1).
REQ-009 mem_addr, mem_ce, mem_we, mem_d  out  ADDR / 1 / 1 / DATA  SHALL drive one shared BRAM port.
REQ-010 mem_q  in  DATA  SHALL be the BRAM read data, valid exactly one cycle after a read enable.
REQ-011 conflict_cnt  out  16  SHALL report the number of cycles in which both requesters were valid.

Function
REQ-012 A request SHALL be accepted in a cycle where valid and ready are both 1; ready SHALL be 1 only for the granted requester.
REQ-013 Grant SHALL be combinational from the current valid inputs and the registered last_grant; at most one ready SHALL be 1 per cycle.
REQ-014 If only one requester is valid, that requester SHALL be granted in the same cycle (zero-wait).
REQ-015 If neither requester is valid, mem_ce and mem_we SHALL be 0 and both ready outputs SHALL be 0.
REQ-016 On acceptance, mem_ce SHALL be 1, and mem_addr, mem_we and mem_d SHALL equal the granted requester's addr, we and d in the same cycle.
REQ-017 last_grant SHALL update to the granted requester's index only on an accepted request; it SHALL hold otherwise.
REQ-018 For an accepted read (we=0) in cycle T, the issuing requester's rvalid SHALL be 1 in cycle T+1 only, with its q equal to mem_q.
REQ-019 An accepted write SHALL produce no rvalid pulse.
REQ-020 The non-issuing requester's rvalid SHALL remain 0; cpu_q and host_q SHALL both carry mem_q when their rvalid is 0.
REQ-021 Back-to-back accepted reads SHALL sustain one request per cycle, with responses returned in issue order.
REQ-022 A write by one requester in cycle T followed by a read of the same address in cycle T+1 SHALL return the written data.
REQ-023 conflict_cnt SHALL increment by 1 in each cycle where cpu_valid and host_valid are both 1, and SHALL saturate at 0xFFFF without wrapping.
REQ-024 A requester SHALL hold valid, we, addr and d stable until it is accepted; the arbiter SHALL NOT require ready before valid.

Reset
REQ-025 While s00_axi_aresetn is 0: cpu_ready, host_ready, mem_ce, mem_we, cpu_rvalid and host_rvalid SHALL be 0; conflict_cnt SHALL be 0; last_grant SHALL be 1 (host), so that the CPU wins the first conflict.
REQ-026 A read accepted in the cycle before reset asserts SHALL have its response discarded: no rvalid pulse after reset.
REQ-027 After reset deasserts, the first valid request SHALL be acceptable on the first clock edge.

Configuration
REQ-028 Macro MANO_ARB_ROUND_ROBIN_EN defined: when both requesters are valid, the requester not equal to last_grant SHALL be granted (strict alternation under continuous contention).
REQ-029 Macro MANO_ARB_ROUND_ROBIN_EN undefined: when both requesters are valid, the CPU SHALL always be granted (fixed priority). last_grant SHALL still update, but it SHALL NOT affect arbitration.

Verification
REQ-030 Reset, then CPU read at 0x010 with BRAM[0x010]=0xDEADBEEF -> cpu_ready=1 in the same cycle; cpu_rvalid=1 and cpu_q=0xDEADBEEF one cycle later; host_rvalid stays 0.
REQ-031 Both requesters assert reads continuously for 4 cycles (RR_EN defined) -> grants CPU,host,CPU,host; conflict_cnt=4; each requester gets 2 responses with correct data.
REQ-032 Same stimulus as REQ-031 with RR_EN undefined -> CPU is granted in all 4 cycles; host_ready stays 0; conflict_cnt=4.
REQ-033 Host writes 0x12345678 to 0xABC, then the CPU reads 0xABC in the next cycle -> cpu_q=0x12345678; no rvalid pulse for the write.
REQ-034 Hold both valid for 70000 cycles -> conflict_cnt=0xFFFF and holds that value.
REQ-035 Accept a CPU read, then assert reset before the next edge -> cpu_rvalid stays 0 and all outputs are at their reset values.

Source files
------------

// File: rtl/mano_bram_arbiter_if.sv
// mano_bram_arbiter_if: CPU/host request ports and shared BRAM port bundle
interface mano_bram_arbiter_if #(
   parameter int MEM0_DATA_WIDTH = 32,
   parameter int MEM0_ADDR_WIDTH = 12
);
   logic                       cpu_valid, cpu_ready, cpu_we, cpu_rvalid;
   logic [MEM0_ADDR_WIDTH-1:0] cpu_addr;
   logic [MEM0_DATA_WIDTH-1:0] cpu_d, cpu_q;
   logic                       host_valid, host_ready, host_we, host_rvalid;
   logic [MEM0_ADDR_WIDTH-1:0] host_addr;
   logic [MEM0_DATA_WIDTH-1:0] host_d, host_q;
   logic [MEM0_ADDR_WIDTH-1:0] mem_addr;
   logic                       mem_ce, mem_we;
   logic [MEM0_DATA_WIDTH-1:0] mem_d, mem_q;
   logic [15:0]                conflict_cnt;

   modport slave (
      input  cpu_valid, cpu_we, cpu_addr, cpu_d,
      input  host_valid, host_we, host_addr, host_d,
      input  mem_q,
      output cpu_ready, cpu_rvalid, cpu_q,
      output host_ready, host_rvalid, host_q,
      output mem_addr, mem_ce, mem_we, mem_d, conflict_cnt
   );

   modport master (
      output cpu_valid, cpu_we, cpu_addr, cpu_d,
      output host_valid, host_we, host_addr, host_d,
      output mem_q,
      input  cpu_ready, cpu_rvalid, cpu_q,
      input  host_ready, host_rvalid, host_q,
      input  mem_addr, mem_ce, mem_we, mem_d, conflict_cnt
   );
endinterface

// File: rtl/mano_bram_arbiter.sv
// mano_bram_arbiter: two-requester BRAM port arbiter; MANO_ARB_ROUND_ROBIN_EN selects round-robin over fixed CPU priority
module mano_bram_arbiter #(
   parameter int MEM0_DATA_WIDTH = 32,
   parameter int MEM0_ADDR_WIDTH = 12
) (
   input logic                 s00_axi_aclk,
   input logic                 s00_axi_aresetn,
   mano_bram_arbiter_if.slave  bus
);
`ifdef MANO_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic                       gnt_cpu, gnt_host, last_grant, rd_cpu, rd_host;
   logic [15:0]                cnt;
   logic [MEM0_ADDR_WIDTH-1:0] addr_sel;
   logic [MEM0_DATA_WIDTH-1:0] d_sel;

   // A lone requester wins at once; contention goes to the CPU unless round-robin hands it to the host after a CPU win
   always_comb begin
      gnt_host = s00_axi_aresetn && bus.host_valid && (!bus.cpu_valid || (RR && !last_grant));
      gnt_cpu  = s00_axi_aresetn && bus.cpu_valid && !gnt_host;
      addr_sel = gnt_host ? bus.host_addr : bus.cpu_addr;
      d_sel    = gnt_host ? bus.host_d : bus.cpu_d;
   end

   // Remember the last winner, flag next-cycle read responses and count contention cycles (saturating)
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         last_grant <= 1'b1;
         rd_cpu     <= 1'b0;
         rd_host    <= 1'b0;
         cnt        <= '0;
      end else begin
         if (gnt_cpu || gnt_host) last_grant <= gnt_host;
         rd_cpu  <= gnt_cpu && !bus.cpu_we;
         rd_host <= gnt_host && !bus.host_we;
         if (bus.cpu_valid && bus.host_valid && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end
   end

   assign bus.cpu_ready    = gnt_cpu;
   assign bus.host_ready   = gnt_host;
   assign bus.mem_ce       = gnt_cpu || gnt_host;
   assign bus.mem_we       = gnt_cpu ? bus.cpu_we : (gnt_host && bus.host_we);
   assign bus.mem_addr     = addr_sel;
   assign bus.mem_d        = d_sel;
   assign bus.cpu_rvalid   = rd_cpu;
   assign bus.host_rvalid  = rd_host;
   assign bus.cpu_q        = bus.mem_q;
   assign bus.host_q       = bus.mem_q;
   assign bus.conflict_cnt = cnt;
endmodule

// File: tb/tb_mano_bram_arbiter.sv
// tb_mano_bram_arbiter: scoreboard bench for mano_bram_arbiter with a behavioural BRAM
module tb_mano_bram_arbiter;
`ifdef MANO_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] bram [0:4095];
   logic [31:0] ref_mem [0:4095];
   logic [31:0] cpu_exp [$];
   logic [31:0] host_exp [$];
   logic        m_last, m_gc, m_gh;
   int          m_cnt, tests, fails;

   mano_bram_arbiter_if bus ();

   mano_bram_arbiter dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   // Single-port BRAM with one-cycle read latency
   always @(posedge clk) begin
      if (bus.mem_ce) begin
         if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_d;
         else bus.mem_q <= bram[bus.mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic cv, cwe, input logic [11:0] ca, input logic [31:0] cd,
                        input logic hv, hwe, input logic [11:0] ha, input logic [31:0] hd);
      bus.cpu_valid = cv;  bus.cpu_we = cwe;  bus.cpu_addr = ca;  bus.cpu_d = cd;
      bus.host_valid = hv; bus.host_we = hwe; bus.host_addr = ha; bus.host_d = hd;
   endtask

   task automatic step(input logic cv, cwe, input logic [11:0] ca, input logic [31:0] cd,
                       input logic hv, hwe, input logic [11:0] ha, input logic [31:0] hd);
      logic rc, rh;
      logic [31:0] e;
      @(negedge clk);
      drive(cv, cwe, ca, cd, hv, hwe, ha, hd);
      #1;
      m_gh = hv && (!cv || (RR && !m_last));
      m_gc = cv && !m_gh;
      check("cpu_ready", bus.cpu_ready, m_gc);
      check("host_ready", bus.host_ready, m_gh);
      check("mem_ce", bus.mem_ce, m_gc || m_gh);
      check("mem_we", bus.mem_we, (m_gc && cwe) || (m_gh && hwe));
      if (m_gc || m_gh) begin
         check("mem_addr", bus.mem_addr, m_gc ? ca : ha);
         check("mem_d", bus.mem_d, m_gc ? cd : hd);
      end
      rc = m_gc && !cwe;
      rh = m_gh && !hwe;
      if (rc) cpu_exp.push_back(ref_mem[ca]);
      if (rh) host_exp.push_back(ref_mem[ha]);
      if (m_gc && cwe) ref_mem[ca] = cd;
      if (m_gh && hwe) ref_mem[ha] = hd;
      if (m_gc || m_gh) m_last = m_gh;
      if (cv && hv && m_cnt < 65535) m_cnt++;
      @(posedge clk);
      #1;
      check("cpu_rvalid", bus.cpu_rvalid, rc);
      check("host_rvalid", bus.host_rvalid, rh);
      if (cpu_exp.size() != 0) begin
         e = cpu_exp.pop_front();
         if (bus.cpu_rvalid) check("cpu_q", bus.cpu_q, e);
      end
      if (host_exp.size() != 0) begin
         e = host_exp.pop_front();
         if (bus.host_rvalid) check("host_q", bus.host_q, e);
      end
      check("conflict_cnt", bus.conflict_cnt, m_cnt);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic        cv, cwe, hv, hwe;
      logic [11:0] ca, ha;
      logic [31:0] cd, hd;
      for (int i = 0; i < 4096; i++) begin
         bram[i] = 32'h1000_0000 + i * 3;
         ref_mem[i] = bram[i];
      end
      bram[12'h010] = 32'hDEADBEEF;
      ref_mem[12'h010] = 32'hDEADBEEF;
      bus.mem_q = '0;
      drive(1, 1, 12'h001, 32'h1, 1, 1, 12'h002, 32'h2);
      repeat (2) @(posedge clk);
      #1;
      check("rst_cpu_ready", bus.cpu_ready, 0);
      check("rst_host_ready", bus.host_ready, 0);
      check("rst_mem_ce", bus.mem_ce, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
      check("rst_host_rvalid", bus.host_rvalid, 0);
      check("rst_conflict_cnt", bus.conflict_cnt, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      m_last = 1'b1;
      m_cnt = 0;
      rst_n = 1'b1;
      // CPU read straight out of reset, then write-then-read across requesters
      step(1, 0, 12'h010, 0, 0, 0, 0, 0);
      idle();
      for (int i = 0; i < 4; i++) step(1, 0, 12'h100 + i, 0, 1, 0, 12'h200 + i, 0);
      idle();
      step(0, 0, 0, 0, 1, 1, 12'hABC, 32'h12345678);
      step(1, 0, 12'hABC, 0, 0, 0, 0, 0);
      idle();
      // Random traffic where a requester holds its request until accepted
      cv = 0; hv = 0; cwe = 0; hwe = 0; ca = 0; ha = 0; cd = 0; hd = 0;
      for (int i = 0; i < 200; i++) begin
         if (!cv || m_gc) begin
            cv = $urandom_range(0, 1) == 1; cwe = $urandom_range(0, 1) == 1;
            ca = 12'($urandom_range(0, 15)); cd = $urandom;
         end
         if (!hv || m_gh) begin
            hv = $urandom_range(0, 1) == 1; hwe = $urandom_range(0, 1) == 1;
            ha = 12'($urandom_range(0, 15)); hd = $urandom;
         end
         step(cv, cwe, ca, cd, hv, hwe, ha, hd);
      end
      // Long contention drives the counter into saturation
      for (int i = 0; i < 70000; i++)
         step(1, 0, 12'($urandom_range(0, 4095)), 0, 1, 0, 12'($urandom_range(0, 4095)), 0);
      step(1, 0, 12'h010, 0, 1, 0, 12'hABC, 0);
      // Reset arrives after a CPU read is accepted but before its edge
      @(negedge clk);
      drive(1, 0, 12'h020, 0, 0, 0, 0, 0);
      #1;
      check("pre_rst_cpu_ready", bus.cpu_ready, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_cpu_ready", bus.cpu_ready, 0);
      check("mid_rst_mem_ce", bus.mem_ce, 0);
      check("mid_rst_conflict_cnt", bus.conflict_cnt, 0);
      @(posedge clk);
      #1;
      check("post_rst_cpu_rvalid", bus.cpu_rvalid, 0);
      check("post_rst_host_rvalid", bus.host_rvalid, 0);
      check("post_rst_mem_we", bus.mem_we, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cpu_exp.delete();
      host_exp.delete();
      m_last = 1'b1;
      m_cnt = 0;
      rst_n = 1'b1;
      step(1, 0, 12'h010, 0, 1, 0, 12'hABC, 0);
      step(1, 0, 12'h011, 0, 1, 0, 12'hABD, 0);
      idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
